// File: rtl/fifo_reader_if.sv
// ---------------------------------------------------------------------------
// fifo_reader_if
//
// Bundles the two handshakes around fifo_reader:
//   FIFO side  : fifo_empty / fifo_data in, fifo_pop out (pop strobe).
//   Stream side: m_valid / m_data out, m_ready in.
//
// Stream handshake: a word transfers on every rising clk edge where
// m_valid and m_ready are both 1; while m_valid=1 and m_ready=0 the producer
// holds m_valid and m_data stable; m_valid never depends on m_ready.
//
// Modports:
//   master - the reader (drives fifo_pop, m_valid, m_data).
//   slave  - the environment (FIFO plus downstream consumer).
// ---------------------------------------------------------------------------
interface fifo_reader_if #(
    parameter int WIDTH = 8
);
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_pop;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_ready;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        input  m_ready,
        output fifo_pop,
        output m_valid,
        output m_data
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        output m_ready,
        input  fifo_pop,
        input  m_valid,
        input  m_data
    );
endinterface

// File: rtl/fifo_reader.sv
// ---------------------------------------------------------------------------
// fifo_reader
//
// Read-side consumer for the synchronous FIFO. It pops the FIFO, captures
// the combinational data_out in the pop cycle and re-presents it as a
// registered valid/ready stream. A two-slot buffer (output register slot0
// plus skid register slot1) keeps one word per cycle under backpressure
// without ever popping an empty FIFO.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   enable     in   permission to pop; 0 stops new pops, buffer still drains
//   bus        if   fifo_reader_if.master (FIFO pop side + output stream)
//   buf_level  out  occupied slots 0..2; this is also the FSM state
//   pop_count  out  words popped since reset, wraps at 2^CNT_WIDTH
// ---------------------------------------------------------------------------
module fifo_reader #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    fifo_reader_if.master        bus,
    output logic [1:0]           buf_level,
    output logic [CNT_WIDTH-1:0] pop_count
);

    // State value equals the number of occupied slots.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] slot0;
    logic [WIDTH-1:0] slot1;
    logic [WIDTH-1:0] slot0_next;
    logic [WIDTH-1:0] slot1_next;
    logic             take;
    logic             pop;

    // A word leaves on take. A pop is allowed while a slot is free, or when
    // FULL but a slot frees this same cycle. Gating with rst_n keeps the
    // strobe low during reset even though the FIFO may hold data.
    assign take = (state != EMPTY) & bus.m_ready;
    assign pop  = rst_n & enable & ~bus.fifo_empty & ((state != FULL) | take);

    assign bus.fifo_pop = pop;
    assign bus.m_valid  = (state != EMPTY);
    assign bus.m_data   = slot0;
    assign buf_level    = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            state <= state_next;
            slot0 <= slot0_next;
            slot1 <= slot1_next;
        end
    end

    // Shift slot1 into slot0 on take, then place the popped word in the
    // lowest slot left free; this keeps word order intact.
    always_comb begin
        state_next = state;
        slot0_next = slot0;
        slot1_next = slot1;
        case (state)
            EMPTY: begin
                if (pop) begin
                    slot0_next = bus.fifo_data;
                    state_next = ONE;
                end
            end
            ONE: begin
                case ({pop, take})
                    2'b10: begin
                        slot1_next = bus.fifo_data;
                        state_next = FULL;
                    end
                    2'b01: begin
                        state_next = EMPTY;
                    end
                    2'b11: begin
                        slot0_next = bus.fifo_data;
                        state_next = ONE;
                    end
                    default: begin
                        state_next = ONE;
                    end
                endcase
            end
            FULL: begin
                // pop without take cannot occur here.
                if (take) begin
                    slot0_next = slot1;
                    if (pop) begin
                        slot1_next = bus.fifo_data;
                        state_next = FULL;
                    end else begin
                        state_next = ONE;
                    end
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pop_count <= '0;
        end else if (pop) begin
            pop_count <= pop_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_reader.sv
module tb_fifo_reader;

    localparam int WIDTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  buf_level;
    logic [15:0] pop_count;
    logic [1:0]  buf_level4;
    logic [3:0]  pop_count4;

    fifo_reader_if #(.WIDTH(WIDTH)) bus ();
    fifo_reader_if #(.WIDTH(WIDTH)) bus4 ();

    // Main DUT with the default 16-bit counter.
    fifo_reader #(.WIDTH(WIDTH), .CNT_WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .bus       (bus.master),
        .buf_level (buf_level),
        .pop_count (pop_count)
    );

    // Twin with a 4-bit counter, run in lockstep for the wrap check.
    fifo_reader #(.WIDTH(WIDTH), .CNT_WIDTH(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .bus       (bus4.master),
        .buf_level (buf_level4),
        .pop_count (pop_count4)
    );

    assign bus4.fifo_empty = bus.fifo_empty;
    assign bus4.fifo_data  = bus.fifo_data;
    assign bus4.m_ready    = bus.m_ready;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [WIDTH-1:0] fifo_q[$];
    logic [WIDTH-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // ---------------- FIFO model / driver tasks ----------------
    task automatic fifo_refresh();
        bus.fifo_empty = (fifo_q.size() == 0);
        bus.fifo_data  = (fifo_q.size() == 0) ? 8'hEE : fifo_q[0];
    endtask

    task automatic push_word(input logic [WIDTH-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        fifo_refresh();
    endtask

    // Inputs change 2 time units after the rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drain(input string tag, input int budget);
        int i = 0;
        while (exp_q.size() != 0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        @(negedge clk);
    endtask

    // FIFO consumes its head at the edge where the reader pops.
    always @(posedge clk) begin
        if (rst_n && bus.fifo_pop && fifo_q.size() > 0)
            void'(fifo_q.pop_front());
        #1;
        fifo_refresh();
    end

    // ---------------- output monitor ----------------
    logic             hold_prev = 1'b0;
    logic [WIDTH-1:0] data_prev = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("pop_in_reset", 32'(bus.fifo_pop), 32'd0);
            hold_prev = 1'b0;
        end else begin
            check("pop_while_empty", 32'(bus.fifo_pop & bus.fifo_empty), 32'd0);
            check("level_le_2", 32'(buf_level <= 2'd2), 32'd1);
            if (hold_prev) begin
                check("hold_valid", 32'(bus.m_valid), 32'd1);
                check("hold_data", 32'(bus.m_data), 32'(data_prev));
            end
            if (bus.m_valid && bus.m_ready) begin
                check("sb_word_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0)
                    check("sb_data", 32'(bus.m_data), 32'(exp_q.pop_front()));
            end
            hold_prev = bus.m_valid && !bus.m_ready;
            data_prev = bus.m_data;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int pops;
        int pushes;
        int n_buf;

        bus.m_ready = 1'b0;
        enable      = 1'b1;
        fifo_refresh();
        rst_n = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #2;
        check("rst_valid", 32'(bus.m_valid), 32'd0);
        check("rst_data", 32'(bus.m_data), 32'd0);
        check("rst_level", 32'(buf_level), 32'd0);
        check("rst_count", 32'(pop_count), 32'd0);
        check("rst_pop", 32'(bus.fifo_pop), 32'd0);
        rst_n = 1'b1;
        bus.m_ready = 1'b1;

        // Idle with empty FIFO
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("idle_pop", 32'(bus.fifo_pop), 32'd0);
            check("idle_valid", 32'(bus.m_valid), 32'd0);
        end
        check("idle_count", 32'(pop_count), 32'd0);

        // Streaming 0x01..0x10
        step();
        for (int i = 1; i <= 16; i++) push_word(8'(i));
        for (int k = 0; k <= 17; k++) begin
            @(negedge clk);
            if (k < 16) check("stream_pop", 32'(bus.fifo_pop), 32'd1);
            if (k == 16) check("stream_pop_stop", 32'(bus.fifo_pop), 32'd0);
            if (k >= 1 && k <= 16) begin
                check("stream_valid", 32'(bus.m_valid), 32'd1);
                check("stream_data", 32'(bus.m_data), 32'(k));
            end
        end
        check("stream_count", 32'(pop_count), 32'd16);
        check("stream_level", 32'(buf_level), 32'd0);

        // Backpressure
        step();
        bus.m_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_word(8'(8'hA0 + i));
        pops = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            pops += int'(bus.fifo_pop);
        end
        check("bp_pops", 32'(pops), 32'd2);
        check("bp_level", 32'(buf_level), 32'd2);
        check("bp_valid", 32'(bus.m_valid), 32'd1);
        check("bp_data", 32'(bus.m_data), 32'hA0);
        step();
        bus.m_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_drain_valid", 32'(bus.m_valid), 32'd1);
            check("bp_drain_data", 32'(bus.m_data), 32'(8'hA0 + k));
        end
        @(negedge clk);
        check("bp_done_valid", 32'(bus.m_valid), 32'd0);
        check("bp_count", 32'(pop_count), 32'd21);

        // Enable gating
        step();
        bus.m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(8'(8'hB0 + i));
        repeat (3) @(negedge clk);
        check("gate_level", 32'(buf_level), 32'd2);
        step();
        enable = 1'b0;
        bus.m_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("gate_pop", 32'(bus.fifo_pop), 32'd0);
            if (k < 2) begin
                check("gate_valid", 32'(bus.m_valid), 32'd1);
                check("gate_data", 32'(bus.m_data), 32'(8'hB0 + k));
            end else begin
                check("gate_empty", 32'(bus.m_valid), 32'd0);
            end
        end
        check("gate_count", 32'(pop_count), 32'd23);
        step();
        enable = 1'b1;
        drain("gate_resume_drain", 20);
        check("gate_resume_count", 32'(pop_count), 32'd25);

        // Asynchronous reset with a full buffer
        step();
        bus.m_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_word(8'(8'hC0 + i));
        repeat (3) @(negedge clk);
        check("ar_level_before", 32'(buf_level), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", 32'(bus.m_valid), 32'd0);
        check("ar_level", 32'(buf_level), 32'd0);
        check("ar_count", 32'(pop_count), 32'd0);
        check("ar_count4", 32'(pop_count4), 32'd0);
        check("ar_data", 32'(bus.m_data), 32'd0);
        check("ar_pop", 32'(bus.fifo_pop), 32'd0);
        // Buffered words are lost; the word still in the FIFO remains.
        n_buf = exp_q.size() - fifo_q.size();
        for (int i = 0; i < n_buf; i++) void'(exp_q.pop_front());
        bus.m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        drain("ar_drain", 20);
        check("ar_after_count", 32'(pop_count), 32'd1);

        // Counter wrap: fresh reset, then 17 pops
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 17; i++) push_word(8'(8'hD0 + i));
        drain("wrap_drain", 60);
        check("wrap_count4", 32'(pop_count4), 32'd1);
        check("wrap_count16", 32'(pop_count), 32'd17);

        // Random traffic
        pushes = 0;
        for (int c = 0; c < 1000; c++) begin
            step();
            bus.m_ready = 1'($urandom_range(0, 1));
            enable      = ($urandom_range(0, 3) != 0);
            if (fifo_q.size() < 6 && $urandom_range(0, 2) != 0) begin
                push_word(8'($urandom_range(0, 255)));
                pushes++;
            end
        end
        step();
        enable = 1'b1;
        bus.m_ready = 1'b1;
        drain("rand_drain", 100);
        check("rand_level", 32'(buf_level), 32'd0);
        check("rand_count16", 32'(pop_count), 32'((17 + pushes) % 65536));
        check("rand_count4", 32'(pop_count4), 32'((17 + pushes) % 16));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, expected completion");
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fifo_reader.md
# fifo_reader

Read-side consumer for the team's synchronous FIFO. It drives the FIFO's `pop` and captures the combinational `data_out`, which is valid only in the cycle `pop` is asserted while the FIFO is non-empty. It re-presents that data as a registered valid/ready stream toward downstream logic. A 2-entry output buffer keeps full throughput under backpressure and ensures the FIFO is never popped while empty.

## Interface
Parameters:
- `WIDTH`, 8, data word width; must match the FIFO.
- `CNT_WIDTH`, 16, width of the popped-word statistics counter.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  permission to pop the FIFO; 0 stops new pops only.
- `fifo_empty`  in  1  FIFO `mem_empty`.
- `fifo_data`  in  WIDTH  FIFO `data_out`; sampled only when `fifo_pop`=1.
- `fifo_pop`  out  1  pop strobe to the FIFO (combinational).
- `m_valid`  out  1  downstream word valid.
- `m_data`  out  WIDTH  downstream word (registered).
- `m_ready`  in  1  downstream accept.
- `buf_level`  out  2  buffered word count, 0..2.
- `pop_count`  out  CNT_WIDTH  total words popped since reset; wraps.

## Operation
- Buffer:
  - slot0 is the output register and drives `m_data`.
  - slot1 is the skid register.
  - `level` counts 0, 1 or 2 occupied slots.
  - `m_valid` = (`level` != 0).
- Transfer rules:
  - `take` = `m_valid & m_ready`.
  - `fifo_pop` = `enable & !fifo_empty & ((level < 2) | take)`.
  - `fifo_pop` must never be 1 while `fifo_empty`=1.
  - `fifo_pop` must be 0 while `rst_n`=0.
- Level update: `level_next` = `level` + `fifo_pop` − `take`.
- Slot update:
  - If `take`, slot1 shifts into slot0.
  - The popped word is written to the lowest slot free after the shift.
  - Word order is strictly preserved.
- Backpressure:
  - While `m_valid`=1 and `m_ready`=0, `m_valid` and `m_data` hold stable.
  - `level`=2 with no `take` stops popping.
- `enable`=0:
  - No pops occur.
  - Already-buffered words still drain to downstream normally.
- `pop_count` increments by 1 on every cycle with `fifo_pop`=1 and wraps at 2^CNT_WIDTH.
- States, encoded by `level`:
  - EMPTY(0) → ONE on pop without take.
  - ONE(1) → EMPTY on take without pop; → FULL on pop without take; stays ONE on pop+take.
  - FULL(2) → ONE on take without pop; stays FULL on pop+take.
- An implementation that observes `level` = 3 is in error; verification asserts that `level` ≤ 2 always.

## Timing
- Reset values (asynchronous, on `rst_n` low): `m_valid`=0, `m_data`=0, `buf_level`=0, `pop_count`=0, both slots 0. `fifo_pop`=0 combinationally.
- Reset deasserting mid-stream: buffered words are discarded. The first pop may occur in the first cycle with `rst_n`=1.
- Latency: a word popped in cycle N, into an empty buffer, appears with `m_valid`=1 in cycle N+1.
- Throughput: with `m_ready`=1, `enable`=1 and the FIFO non-empty, the block sustains one word per cycle.
- Paths:
  - Combinational path exists from `m_ready`, `fifo_empty` and `enable` to `fifo_pop`.
  - No combinational path exists to `m_valid` or `m_data`.
- FIFO going empty: a pop in the FIFO's last-entry cycle is legal. `fifo_pop` drops in the following cycle when `fifo_empty` rises.

## Test plan
- Reset then idle:
  - Stimulus: FIFO empty, `enable`=1.
  - Required: `fifo_pop`=0 and `m_valid`=0 for 20 cycles, `pop_count`=0.
- Streaming:
  - Stimulus: FIFO pre-loaded with 0x01..0x10, `m_ready`=1.
  - Required: 16 consecutive pops; `m_data` 0x01..0x10 on cycles 1..16 after the first pop; `pop_count`=16; `buf_level` returns to 0.
- Backpressure:
  - Stimulus: FIFO holds 0xA0..0xA4, `m_ready`=0.
  - Required: exactly 2 pops, then `buf_level`=2, `m_data`=0xA0 held stable.
  - Stimulus: then raise `m_ready`.
  - Required: 0xA0..0xA4 delivered in order at one per cycle.
- Enable gating:
  - Stimulus: `buf_level`=2, deassert `enable`, `m_ready`=1.
  - Required: 2 words drained, no pops, `m_valid`=0 after 2 cycles; `pop_count` unchanged.
- Async reset mid-operation:
  - Stimulus: assert `rst_n`=0 between clock edges with `buf_level`=2.
  - Required: `m_valid`, `buf_level` and `pop_count` are 0 immediately, without waiting for an edge; `fifo_pop`=0 throughout reset.
- Counter wrap and random traffic:
  - Stimulus: `CNT_WIDTH`=4, 17 pops, then 1000 cycles of random `m_ready`/`enable`.
  - Required: `pop_count`=1 after the 17 pops. For the random phase, a scoreboard confirms in-order data with no loss or duplication, and `fifo_pop` is never asserted while `fifo_empty`=1.
